// File: rtl/acl_spi_responder.sv
// acl_spi_responder: behavioural-synthesizable ADXL362-style SPI slave (mode 0, MSB first).
// Commands: 0x0A write, 0x0B read, then address byte and auto-incrementing data bytes.
// The 64-byte map holds the ID constants, the X/Y/Z sample registers and read/write control registers 0x20-0x2E.
// Define ACL_RESP_STATUS_EN to add the STATUS register (DATA_READY in bit 0) at 0x0B.
module acl_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  DEVID_AD    = 8'hAD,
  parameter logic [7:0]  DEVID_MST   = 8'h1D,
  parameter logic [7:0]  PARTID      = 8'hF2
) (
  input  logic       CLK100MHZ,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] x_data,
  input  logic [7:0] y_data,
  input  logic [7:0] z_data,
  input  logic       data_valid,
  output logic [7:0] power_ctl,
  output logic       measure_on,
  output logic       wr_strobe,
  output logic       txn_done
);

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned ADDR_W   = 6;
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned RW_SLOTS = 16;

  localparam logic [BYTE_W-1:0] CMD_WRITE = 8'h0A;
  localparam logic [BYTE_W-1:0] CMD_READ  = 8'h0B;
  localparam logic [ADDR_W-1:0] RW_BASE   = 6'h20;
  localparam logic [ADDR_W-1:0] RW_LAST   = 6'h2E;
  localparam logic [ADDR_W-1:0] PWR_ADDR  = 6'h2D;
  localparam logic [ADDR_W-1:0] Z_ADDR    = 6'h0A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_RDATA,
    ST_WDATA,
    ST_IGNORE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic sclk_s;
  logic cs_s;
  logic mosi_s;
  logic sclk_d;
  logic cs_d;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_rise;
  logic cs_fall;

  logic [CNT_W-1:0]  bit_cnt;
  logic [BYTE_W-2:0] rx_sh;
  logic [BYTE_W-1:0] rx_byte;
  logic              byte_rx;
  logic              is_read;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_inc;
  logic [BYTE_W-1:0] tx_sh;

  logic [ADDR_W-1:0] rd_addr;
  logic [BYTE_W-1:0] rd_val;
  logic [BYTE_W-1:0] status_val;

  logic [BYTE_W-1:0] rw_regs [RW_SLOTS];
  logic [BYTE_W-1:0] x_reg;
  logic [BYTE_W-1:0] y_reg;
  logic [BYTE_W-1:0] z_reg;
  logic [BYTE_W-1:0] x_pend;
  logic [BYTE_W-1:0] y_pend;
  logic [BYTE_W-1:0] z_pend;
  logic              pend_valid;
  logic              apply_new;
  logic              apply_pend;
  logic              sample_apply;
  logic              ptr_writable;

  // FSM control strobes
  logic cnt_clr;
  logic shift_en;
  logic set_cmd;
  logic load_ptr;
  logic rd_load_first;
  logic rd_next;
  logic tx_shift;
  logic wr_commit;
  logic wr_next;
  logic miso_clr;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;

  assign rx_byte      = {rx_sh, mosi_s};
  assign byte_rx      = sclk_rise && (bit_cnt == CNT_W'(7));
  assign ptr_inc      = ptr + ADDR_W'(1);
  assign ptr_writable = (ptr >= RW_BASE) && (ptr <= RW_LAST);
  assign power_ctl    = rw_regs[PWR_ADDR[3:0]];

  // Synchronize the asynchronous SPI inputs and keep one delayed copy for edge detection
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  // FSM state register
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: chip-select release returns to IDLE from anywhere
  always_comb begin
    state_nxt = state;
    if (cs_rise) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (cs_fall) state_nxt = ST_CMD;
        ST_CMD: begin
          if (byte_rx) begin
            if ((rx_byte == CMD_READ) || (rx_byte == CMD_WRITE)) state_nxt = ST_ADDR;
            else                                                 state_nxt = ST_IGNORE;
          end
        end
        ST_ADDR: if (byte_rx) state_nxt = is_read ? ST_RDATA : ST_WDATA;
        default: ;
      endcase
    end
  end

  // FSM outputs: per-state datapath strobes, all suppressed on chip-select release
  always_comb begin
    cnt_clr       = 1'b0;
    shift_en      = 1'b0;
    set_cmd       = 1'b0;
    load_ptr      = 1'b0;
    rd_load_first = 1'b0;
    rd_next       = 1'b0;
    tx_shift      = 1'b0;
    wr_commit     = 1'b0;
    wr_next       = 1'b0;
    miso_clr      = 1'b0;
    if (cs_rise) begin
      miso_clr = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt_clr  = cs_fall;
          miso_clr = 1'b1;
        end
        ST_CMD: begin
          shift_en = sclk_rise;
          set_cmd  = byte_rx;
        end
        ST_ADDR: begin
          shift_en      = sclk_rise;
          load_ptr      = byte_rx;
          rd_load_first = byte_rx && is_read;
        end
        ST_RDATA: begin
          shift_en = sclk_rise;
          tx_shift = sclk_fall;
          rd_next  = byte_rx;
        end
        ST_WDATA: begin
          shift_en  = sclk_rise;
          wr_commit = byte_rx && ptr_writable;
          wr_next   = byte_rx;
        end
        ST_IGNORE: miso_clr = 1'b1;
        default:   miso_clr = 1'b1;
      endcase
    end
  end

  // Read address: the freshly received address on entry to RDATA, otherwise the next pointer
  assign rd_addr = load_ptr ? rx_byte[ADDR_W-1:0] : ptr_inc;

  // Register map read mux
  always_comb begin
    rd_val = 8'h00;
    if ((rd_addr >= RW_BASE) && (rd_addr <= RW_LAST)) begin
      rd_val = rw_regs[rd_addr[3:0]];
    end else begin
      case (rd_addr)
        6'h00:   rd_val = DEVID_AD;
        6'h01:   rd_val = DEVID_MST;
        6'h02:   rd_val = PARTID;
        6'h08:   rd_val = x_reg;
        6'h09:   rd_val = y_reg;
        6'h0A:   rd_val = z_reg;
        6'h0B:   rd_val = status_val;
        default: rd_val = 8'h00;
      endcase
    end
  end

  // Serial datapath: bit counter, receive shifter, pointer, transmit shifter and miso
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      bit_cnt  <= '0;
      rx_sh    <= '0;
      is_read  <= 1'b0;
      ptr      <= '0;
      tx_sh    <= '0;
      miso     <= 1'b0;
      txn_done <= 1'b0;
    end else begin
      txn_done <= cs_rise && (state != ST_IDLE);
      if (cnt_clr)       bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + CNT_W'(1);
      if (shift_en) rx_sh <= rx_byte[BYTE_W-2:0];
      if (set_cmd)  is_read <= (rx_byte == CMD_READ);
      if (load_ptr)                ptr <= rx_byte[ADDR_W-1:0];
      else if (rd_next || wr_next) ptr <= ptr_inc;
      // The first byte's MSB goes out at once; later bytes present their MSB on the following fall
      if (rd_load_first) begin
        tx_sh <= rd_val;
        miso  <= rd_val[BYTE_W-1];
      end else if (rd_next) begin
        tx_sh <= rd_val;
      end else if (tx_shift) begin
        miso  <= tx_sh[BYTE_W-1];
        tx_sh <= {tx_sh[BYTE_W-2:0], 1'b0};
      end
      if (miso_clr) miso <= 1'b0;
    end
  end

  // Writable control registers and write strobe
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      for (int i = 0; i < int'(RW_SLOTS); i++) rw_regs[i] <= '0;
      wr_strobe  <= 1'b0;
      measure_on <= 1'b0;
    end else begin
      wr_strobe <= wr_commit;
      if (wr_commit) begin
        rw_regs[ptr[3:0]] <= rx_byte;
        if (ptr == PWR_ADDR) measure_on <= (rx_byte[1:0] == 2'b10);
      end
    end
  end

  // Samples go straight in while deselected; otherwise the latest is parked until cs_n rises
  assign apply_new    = data_valid && cs_s;
  assign apply_pend   = cs_rise && pend_valid && !data_valid;
  assign sample_apply = apply_new || apply_pend;

  // Sample registers and pending sample
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      x_reg      <= '0;
      y_reg      <= '0;
      z_reg      <= '0;
      x_pend     <= '0;
      y_pend     <= '0;
      z_pend     <= '0;
      pend_valid <= 1'b0;
    end else begin
      if (apply_new) begin
        x_reg <= x_data;
        y_reg <= y_data;
        z_reg <= z_data;
      end else if (apply_pend) begin
        x_reg <= x_pend;
        y_reg <= y_pend;
        z_reg <= z_pend;
      end
      if (data_valid && !cs_s) begin
        x_pend     <= x_data;
        y_pend     <= y_data;
        z_pend     <= z_data;
        pend_valid <= 1'b1;
      end else if (cs_rise) begin
        pend_valid <= 1'b0;
      end
    end
  end

`ifdef ACL_RESP_STATUS_EN
  logic data_ready;
  logic z_read;

  // DATA_READY: set by a sample, cleared when a burst that delivered ZDATA ends
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      data_ready <= 1'b0;
      z_read     <= 1'b0;
    end else begin
      if (cs_rise)                        z_read <= 1'b0;
      else if (rd_next && (ptr == Z_ADDR)) z_read <= 1'b1;
      if (sample_apply)            data_ready <= 1'b1;
      else if (cs_rise && z_read)  data_ready <= 1'b0;
    end
  end

  assign status_val = {7'b0, data_ready};
`else
  assign status_val = 8'h00;
`endif

endmodule

// File: tb/tb_acl_spi_responder.sv
// tb_acl_spi_responder: directed plus randomized SPI transactions against a register-map reference model.
module tb_acl_spi_responder;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic [7:0] x_data;
  logic [7:0] y_data;
  logic [7:0] z_data;
  logic       data_valid;
  logic [7:0] power_ctl;
  logic       measure_on;
  logic       wr_strobe;
  logic       txn_done;

  always #5 clk = ~clk;

  acl_spi_responder dut (
    .CLK100MHZ  (clk),
    .rst        (rst),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .miso       (miso),
    .x_data     (x_data),
    .y_data     (y_data),
    .z_data     (z_data),
    .data_valid (data_valid),
    .power_ctl  (power_ctl),
    .measure_on (measure_on),
    .wr_strobe  (wr_strobe),
    .txn_done   (txn_done)
  );

  int vectors    = 0;
  int miscompares = 0;
  int strobe_cnt = 0;
  int txn_cnt    = 0;

  always @(negedge clk) begin
    if (wr_strobe) strobe_cnt++;
    if (txn_done)  txn_cnt++;
  end

  // Reference model of the register map
  logic [7:0] m_rw [64];
  logic [7:0] m_x, m_y, m_z;
  logic [7:0] p_x, p_y, p_z;
  bit         m_pend;
  bit         m_busy;
  bit         m_dr;
  bit         z_seen;

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_rw[i] = 8'h00;
    m_x = 8'h00; m_y = 8'h00; m_z = 8'h00;
    m_pend = 0; m_busy = 0; m_dr = 0; z_seen = 0;
  endtask

  function automatic logic [7:0] m_read(input int a);
    if (a == 0)  return 8'hAD;
    if (a == 1)  return 8'h1D;
    if (a == 2)  return 8'hF2;
    if (a == 8)  return m_x;
    if (a == 9)  return m_y;
    if (a == 10) return m_z;
`ifdef ACL_RESP_STATUS_EN
    if (a == 11) return {7'b0, m_dr};
`endif
    if (a >= 32 && a <= 46) return m_rw[a];
    return 8'h00;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = tx[7-i];
      repeat (HALF) @(negedge clk);
      rx = {rx[6:0], miso};
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_begin();
    @(negedge clk);
    cs_n   = 1'b0;
    m_busy = 1;
    z_seen = 0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic spi_end();
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    if (z_seen) m_dr = 0;
    if (m_pend) begin
      m_x = p_x; m_y = p_y; m_z = p_z; m_dr = 1;
    end
    m_pend = 0;
    m_busy = 0;
    repeat (2*HALF) @(negedge clk);
  endtask

  task automatic inject(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
    @(negedge clk);
    x_data = x; y_data = y; z_data = z;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    if (m_busy) begin
      p_x = x; p_y = y; p_z = z; m_pend = 1;
    end else begin
      m_x = x; m_y = y; m_z = z; m_dr = 1;
    end
  endtask

  task automatic read_byte(input string tag, inout logic [5:0] a);
    logic [7:0] rx;
    spi_bits(8'h00, 8, rx);
    check($sformatf("%s@%02h", tag, a), rx, m_read(int'(a)));
    if (a == 6'h0A) z_seen = 1;
    a = a + 6'd1;
  endtask

  task automatic read_head(input logic [5:0] addr);
    logic [7:0] rx;
    logic [1:0] junk;
    junk = 2'($urandom);
    spi_begin();
    spi_bits(8'h0B, 8, rx);
    spi_bits({junk, addr}, 8, rx);
  endtask

  task automatic read_burst(input logic [5:0] addr, input int n, input string tag);
    logic [5:0] a;
    read_head(addr);
    a = addr;
    for (int k = 0; k < n; k++) read_byte(tag, a);
    spi_end();
  endtask

  task automatic write_burst(input logic [5:0] addr, input logic [7:0] d[$], input string tag);
    logic [7:0] rx;
    logic [5:0] a;
    int s0;
    int exp_str;
    s0 = strobe_cnt;
    exp_str = 0;
    spi_begin();
    spi_bits(8'h0A, 8, rx);
    spi_bits({2'b00, addr}, 8, rx);
    a = addr;
    foreach (d[k]) begin
      spi_bits(d[k], 8, rx);
      if (a >= 6'h20 && a <= 6'h2E) begin
        m_rw[a] = d[k];
        exp_str++;
      end
      a = a + 6'd1;
    end
    spi_end();
    check({tag, "_strobes"}, 8'(strobe_cnt - s0), 8'(exp_str));
    check({tag, "_power_ctl"}, power_ctl, m_rw[6'h2D]);
    check({tag, "_measure_on"}, 8'(measure_on), 8'(m_rw[6'h2D][1:0] == 2'b10));
  endtask

  initial begin
    logic [7:0] rx;
    logic [5:0] a;
    logic [7:0] d[$];
    int s0;
    int t0;

    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    x_data = 8'h00; y_data = 8'h00; z_data = 8'h00; data_valid = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_miso", 8'(miso), 8'h00);
    check("rst_power_ctl", power_ctl, 8'h00);
    check("rst_measure_on", 8'(measure_on), 8'h00);
    check("rst_wr_strobe", 8'(wr_strobe), 8'h00);
    check("rst_txn_done", 8'(txn_done), 8'h00);

    // ID registers and a single txn_done pulse
    t0 = txn_cnt;
    read_burst(6'h00, 3, "id");
    check("id_txn_done", 8'(txn_cnt - t0), 8'd1);

    // Power control write and readback
    d = {8'h02};
    write_burst(6'h2D, d, "pwr");
    read_burst(6'h2D, 1, "pwr_rd");

    // Sample coherency across a burst
    inject(8'h11, 8'h22, 8'h33);
    read_burst(6'h08, 4, "smp");
    read_head(6'h08);
    a = 6'h08;
    read_byte("smp_mid", a);
    inject(8'h44, 8'h55, 8'h66);
    read_byte("smp_mid", a);
    read_byte("smp_mid", a);
    spi_end();
    read_burst(6'h0B, 1, "status_set");
    read_burst(6'h08, 3, "smp_new");
    read_burst(6'h0B, 1, "status_clr");

    // Write burst crossing the map end
    d = {8'hA1, 8'hA2, 8'hA3};
    write_burst(6'h3E, d, "wrap_hi");
    d = {8'hA1, 8'hA2, 8'hA3};
    write_burst(6'h2E, d, "wrap");
    read_burst(6'h2E, 3, "wrap_rd");
    read_burst(6'h3F, 2, "wrap_rd2");

    // Unknown command is ignored
    s0 = strobe_cnt;
    spi_begin();
    spi_bits(8'h55, 8, rx);
    spi_bits(8'hFF, 8, rx);
    check("ignore_miso0", rx, 8'h00);
    spi_bits(8'hFF, 8, rx);
    check("ignore_miso1", rx, 8'h00);
    spi_end();
    check("ignore_strobes", 8'(strobe_cnt - s0), 8'd0);

    // Partial data byte is discarded
    s0 = strobe_cnt;
    spi_begin();
    spi_bits(8'h0A, 8, rx);
    spi_bits(8'h2D, 8, rx);
    spi_bits(8'hFF, 5, rx);
    spi_end();
    check("abort_strobes", 8'(strobe_cnt - s0), 8'd0);
    check("abort_power_ctl", power_ctl, m_rw[6'h2D]);
    read_burst(6'h2D, 1, "abort_rd");

    // Randomized write/read traffic with occasional samples
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 1) == 1)
        inject(8'($urandom), 8'($urandom), 8'($urandom));
      d = {};
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) d.push_back(8'($urandom));
      write_burst(6'($urandom_range(6'h1C, 6'h3F)), d, "rnd_wr");
      read_burst(6'($urandom_range(0, 63)), int'($urandom_range(1, 4)), "rnd_rd");
      read_burst(6'($urandom_range(6'h20, 6'h2E)), 2, "rnd_rw");
    end

    // Reset in the middle of a read
    read_head(6'h02);
    spi_bits(8'h00, 3, rx);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_miso", 8'(miso), 8'h00);
    cs_n = 1'b1;
    sclk = 1'b0;
    t0 = txn_cnt;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2*HALF) @(negedge clk);
    check("midrst_txn_done", 8'(txn_cnt - t0), 8'd0);
    check("midrst_power_ctl", power_ctl, 8'h00);
    check("midrst_measure_on", 8'(measure_on), 8'h00);
    read_burst(6'h00, 3, "post_rst");
    read_burst(6'h20, 2, "post_rst_rw");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
